css_feeder: RTL and testbench
=============================

# css_feeder

Producer side of the 3x3 column shift structure. Reads a feature map one word at a time from a single-port external memory and drives the three row inputs plus load-enable and shift controls, so the shift structure always holds a valid 3x3 window. Announces each complete window to downstream compute with a valid/ready handshake. Sits between the external memory read port and the shift structure in the convolution datapath.

## Interface
- IO_DATA_WIDTH, 16, word width of memory data and row outputs
- ADDR_WIDTH, 20, external memory address width
- FEATURE_MAP_WIDTH, 1024, columns per feature map (W, must be ≥3)
- FEATURE_MAP_HEIGHT, 1024, rows per feature map (H, must be ≥3)

- clk  input  1  clock; all logic on rising edge
- rst_in  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse; begins a pass over the map; ignored while busy
- base_addr  input  ADDR_WIDTH  address of pixel (0,0); sampled on accepted start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the last window is accepted
- mem_re  output  1  read strobe
- mem_addr  output  ADDR_WIDTH  read address; mem_rdata valid exactly 1 cycle after mem_re
- mem_rdata  input  IO_DATA_WIDTH  read data
- row_1, row_2, row_3  output  IO_DATA_WIDTH each  registered column words for window rows r, r+1, r+2
- LE  output  1  load enable to shift structure input registers
- shift  output  1  shift enable to shift structure
- win_valid  output  1  shift structure holds a complete window
- win_ready  input  1  downstream accepts window
- win_row  output  clog2(H)  top row r of current window
- win_col  output  clog2(W)  left column of current window (c−2)

## Operation
- Address of pixel (y,x) = base_addr + y·W + x, modulo 2^ADDR_WIDTH; computed incrementally (no multiplier).
- Pass: r = 0..H−3, c = 0..W−1 per r, row-major; per column, fetch (r,c), (r+1,c), (r+2,c).
- FSM states: IDLE, RD0, RD1, RD2, CAP, LOAD, SHIFT, VALID, DONE.
  - IDLE: start → RD0; r=c=0.
  - RD0: mem_re=1, addr (r,c). RD1: mem_re=1, addr (r+1,c); row_1 ← mem_rdata. RD2: mem_re=1, addr (r+2,c); row_2 ← mem_rdata. CAP: row_3 ← mem_rdata.
  - LOAD: LE=1. SHIFT: shift=1; then VALID if c≥2, else c++ → RD0.
  - VALID: win_valid=1, win_row=r, win_col=c−2; hold until win_ready; on handshake: if c<W−1 then c++ → RD0; else if r<H−3 then r++, c=0 → RD0; else → DONE.
  - DONE: done=1 for one cycle → IDLE.
- LE and shift never asserted in the same cycle; shift never asserted while win_valid=1.
- Row change restarts column count; stale columns from the previous row are flushed by requiring 3 new shifts before win_valid.
- Total windows per pass: (H−2)·(W−2).

## Timing
- Reset values: busy=0, done=0, mem_re=0, mem_addr=0, row_1..3=0, LE=0, shift=0, win_valid=0, win_row=0, win_col=0; FSM IDLE.
- Reset mid-pass: returns to IDLE next cycle, no done pulse; outstanding read data discarded.
- Per column without stall: 6 cycles (RD0..SHIFT); +1 VALID cycle minimum when c≥2.
- First win_valid: 18 cycles after RD0 entry for c=0 (3 columns × 6), i.e. VALID entered in cycle 18.
- win_valid, win_row, win_col stable until handshake; win_ready while win_valid=0 has no effect.
- start during busy and start coincident with done: ignored.
- All outputs registered except none; no combinational path from mem_rdata or win_ready to any output.

## Structure
- Shared package css_pkg: FSM state enum, ADDR_WIDTH default, clog2-derived counter widths for W and H.
- One sub-module: css_addr_gen — holds row base (base_addr + r·W) and per-row offsets, increments on column/row advance, outputs address for row k∈{0,1,2}.

## Test plan
- W=H=3, base 0, mem[i]=i, win_ready=1 → exactly 1 window, win_row=0, win_col=0; shift structure holds 0..8; done 1 cycle after handshake.
- W=5, H=4, base 0x100 → 6 windows in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); read addresses for column c of row r = 0x100+(r+k)·5+c.
- win_ready held 0 for 10 cycles at first window → win_valid, win_row, win_col stable, no mem_re, no shift during stall.
- Reset asserted in RD1 of second column → next cycle all outputs at reset values, busy=0, no done.
- start pulsed while busy and in done cycle → ignored; single pass, single done pulse.
- base_addr=2^20−2, W=H=3 → addresses wrap to 0x00000.. correctly.

Source files
------------

// File: rtl/css_pkg.sv
// Shared types and width helpers for the 3x3 column-shift feeder.
package css_pkg;

  localparam int CSS_ADDR_WIDTH    = 20;
  localparam int CSS_IO_DATA_WIDTH = 16;
  localparam int CSS_FM_WIDTH      = 1024;
  localparam int CSS_FM_HEIGHT     = 1024;

  typedef enum logic [3:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    CAP,
    LOAD,
    SHIFT,
    VALID,
    DONE
  } css_state_e;

  // Which of the three window rows (r, r+1, r+2) an address is formed for.
  typedef enum logic [1:0] {
    ROW_K0,
    ROW_K1,
    ROW_K2
  } css_row_k_e;

  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/css_feeder_if.sv
// Memory read port and shift-structure / window handshake bundle of the feeder.
interface css_feeder_if #(
  parameter int IO_DATA_WIDTH      = css_pkg::CSS_IO_DATA_WIDTH,
  parameter int ADDR_WIDTH         = css_pkg::CSS_ADDR_WIDTH,
  parameter int FEATURE_MAP_WIDTH  = css_pkg::CSS_FM_WIDTH,
  parameter int FEATURE_MAP_HEIGHT = css_pkg::CSS_FM_HEIGHT
);
  localparam int CW = css_pkg::cnt_w(FEATURE_MAP_WIDTH);
  localparam int RW = css_pkg::cnt_w(FEATURE_MAP_HEIGHT);

  logic                     mem_re;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [IO_DATA_WIDTH-1:0] mem_rdata;
  logic [IO_DATA_WIDTH-1:0] row_1;
  logic [IO_DATA_WIDTH-1:0] row_2;
  logic [IO_DATA_WIDTH-1:0] row_3;
  logic                     LE;
  logic                     shift;
  logic                     win_valid;
  logic                     win_ready;
  logic [RW-1:0]            win_row;
  logic [CW-1:0]            win_col;

  modport master (
    output mem_re, mem_addr, row_1, row_2, row_3, LE, shift,
           win_valid, win_row, win_col,
    input  mem_rdata, win_ready
  );

  modport slave (
    input  mem_re, mem_addr, row_1, row_2, row_3, LE, shift,
           win_valid, win_row, win_col,
    output mem_rdata, win_ready
  );

endinterface

// File: rtl/css_addr_gen.sv
// Incremental pixel address generator: row base plus running column address,
// with a look-ahead output reflecting this cycle's advance command.
module css_addr_gen import css_pkg::*; #(
  parameter int ADDR_WIDTH        = CSS_ADDR_WIDTH,
  parameter int FEATURE_MAP_WIDTH = CSS_FM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic                  col_inc_i,
  input  logic                  row_inc_i,
  input  css_row_k_e            k_i,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam logic [ADDR_WIDTH-1:0] W1 = ADDR_WIDTH'(FEATURE_MAP_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] W2 = ADDR_WIDTH'(2 * FEATURE_MAP_WIDTH);

  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] col_addr_q, col_addr_d;

  always_comb begin
    row_base_d = row_base_q;
    col_addr_d = col_addr_q;
    if (load_i) begin
      row_base_d = base_i;
      col_addr_d = base_i;
    end else if (row_inc_i) begin
      row_base_d = row_base_q + W1;
      col_addr_d = row_base_q + W1;
    end else if (col_inc_i) begin
      col_addr_d = col_addr_q + ADDR_WIDTH'(1);
    end
  end

  // Wrap modulo 2^ADDR_WIDTH falls out of the truncating adds.
  always_comb begin
    unique case (k_i)
      ROW_K1:  addr_o = col_addr_d + W1;
      ROW_K2:  addr_o = col_addr_d + W2;
      default: addr_o = col_addr_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      row_base_q <= '0;
      col_addr_q <= '0;
    end else begin
      row_base_q <= row_base_d;
      col_addr_q <= col_addr_d;
    end
  end

endmodule

// File: rtl/css_feeder.sv
// Walks a feature map column by column, three rows at a time, loading the 3x3
// shift structure and offering each complete window over a valid/ready handshake.
module css_feeder import css_pkg::*; #(
  parameter int IO_DATA_WIDTH      = CSS_IO_DATA_WIDTH,
  parameter int ADDR_WIDTH         = CSS_ADDR_WIDTH,
  parameter int FEATURE_MAP_WIDTH  = CSS_FM_WIDTH,
  parameter int FEATURE_MAP_HEIGHT = CSS_FM_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  css_feeder_if.master          bus
);

  localparam int CW = cnt_w(FEATURE_MAP_WIDTH);
  localparam int RW = cnt_w(FEATURE_MAP_HEIGHT);
  localparam logic [CW-1:0] COL_LAST  = CW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);
  localparam logic [RW-1:0] ROW_LAST  = RW'(FEATURE_MAP_HEIGHT - 3);

  css_state_e               state_q;
  logic [CW-1:0]            c_q;
  logic [RW-1:0]            r_q;
  logic                     busy_q, done_q;
  logic                     mem_re_q;
  logic [ADDR_WIDTH-1:0]    mem_addr_q;
  logic [IO_DATA_WIDTH-1:0] row_1_q, row_2_q, row_3_q;
  logic                     le_q, shift_q, win_valid_q;
  logic [RW-1:0]            win_row_q;
  logic [CW-1:0]            win_col_q;

  logic                     hs;
  logic                     cmd_load, cmd_col, cmd_row;
  css_row_k_e               k_sel;
  logic [ADDR_WIDTH-1:0]    addr_nxt;

  // Advance commands are decoded once here so the address generator and the
  // FSM below always agree on where the next read goes.
  always_comb begin
    hs       = (state_q == VALID) && bus.win_ready;
    cmd_load = (state_q == IDLE) && start;
    cmd_col  = ((state_q == SHIFT) && (c_q < COL_FIRST)) || (hs && (c_q != COL_LAST));
    cmd_row  = hs && (c_q == COL_LAST) && (r_q != ROW_LAST);
    unique case (state_q)
      RD0:     k_sel = ROW_K1;
      RD1:     k_sel = ROW_K2;
      default: k_sel = ROW_K0;
    endcase
  end

  css_addr_gen #(
    .ADDR_WIDTH        (ADDR_WIDTH),
    .FEATURE_MAP_WIDTH (FEATURE_MAP_WIDTH)
  ) u_addr_gen (
    .clk       (clk),
    .rst_in    (rst_in),
    .load_i    (cmd_load),
    .base_i    (base_addr),
    .col_inc_i (cmd_col),
    .row_inc_i (cmd_row),
    .k_i       (k_sel),
    .addr_o    (addr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= IDLE;
      c_q         <= '0;
      r_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      row_1_q     <= '0;
      row_2_q     <= '0;
      row_3_q     <= '0;
      le_q        <= 1'b0;
      shift_q     <= 1'b0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      mem_re_q <= 1'b0;
      le_q     <= 1'b0;
      shift_q  <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_load) begin
            state_q    <= RD0;
            c_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b1;
            mem_re_q   <= 1'b1;
            mem_addr_q <= addr_nxt;
          end
        end
        RD0: begin
          state_q    <= RD1;
          mem_re_q   <= 1'b1;
          mem_addr_q <= addr_nxt;
        end
        // Read data lags its strobe by one cycle, so each row lands one state late.
        RD1: begin
          row_1_q    <= bus.mem_rdata;
          state_q    <= RD2;
          mem_re_q   <= 1'b1;
          mem_addr_q <= addr_nxt;
        end
        RD2: begin
          row_2_q <= bus.mem_rdata;
          state_q <= CAP;
        end
        CAP: begin
          row_3_q <= bus.mem_rdata;
          state_q <= LOAD;
          le_q    <= 1'b1;
        end
        LOAD: begin
          state_q <= SHIFT;
          shift_q <= 1'b1;
        end
        // Three fresh shifts after a row change flush the previous row's columns.
        SHIFT: begin
          if (c_q >= COL_FIRST) begin
            state_q     <= VALID;
            win_valid_q <= 1'b1;
            win_row_q   <= r_q;
            win_col_q   <= c_q - COL_FIRST;
          end else begin
            c_q        <= c_q + CW'(1);
            state_q    <= RD0;
            mem_re_q   <= 1'b1;
            mem_addr_q <= addr_nxt;
          end
        end
        VALID: begin
          if (hs) begin
            win_valid_q <= 1'b0;
            if (cmd_col) begin
              c_q        <= c_q + CW'(1);
              state_q    <= RD0;
              mem_re_q   <= 1'b1;
              mem_addr_q <= addr_nxt;
            end else if (cmd_row) begin
              r_q        <= r_q + RW'(1);
              c_q        <= '0;
              state_q    <= RD0;
              mem_re_q   <= 1'b1;
              mem_addr_q <= addr_nxt;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.row_1     = row_1_q;
  assign bus.row_2     = row_2_q;
  assign bus.row_3     = row_3_q;
  assign bus.LE        = le_q;
  assign bus.shift     = shift_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;

endmodule

// File: tb/tb_css_feeder.sv
// Bench for css_feeder: two map geometries, a 1-cycle-latency memory model and
// a reference built from the pass order (reads per column, windows per row).
module tb_css_feeder;

  localparam int AW = 20;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start3 = 1'b0, start5 = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] base = '0;
  logic [DW-1:0] seed = '0;
  logic          busy3, done3, busy5, done5;
  int            sel = 0;

  css_feeder_if #(.IO_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(3), .FEATURE_MAP_HEIGHT(3)) b3 ();
  css_feeder_if #(.IO_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(5), .FEATURE_MAP_HEIGHT(4)) b5 ();

  css_feeder #(.IO_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(3), .FEATURE_MAP_HEIGHT(3)) u3 (
    .clk(clk), .rst_in(rst), .start(start3), .base_addr(base), .busy(busy3), .done(done3), .bus(b3.master));
  css_feeder #(.IO_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(5), .FEATURE_MAP_HEIGHT(4)) u5 (
    .clk(clk), .rst_in(rst), .start(start5), .base_addr(base), .busy(busy5), .done(done5), .bus(b5.master));

  function automatic logic [DW-1:0] dfun(input logic [AW-1:0] a);
    return a[15:0] ^ {a[19:16], 12'h000} ^ seed;
  endfunction

  assign b3.win_ready = ready;
  assign b5.win_ready = ready;

  // Garbage on non-read cycles exposes any capture taken at the wrong time.
  always @(posedge clk) begin
    b3.mem_rdata <= b3.mem_re ? dfun(b3.mem_addr) : DW'($urandom);
    b5.mem_rdata <= b5.mem_re ? dfun(b5.mem_addr) : DW'($urandom);
  end

  logic          g_re, g_le, g_sh, g_wv, g_busy, g_done;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_r1, g_r2, g_r3;
  int            g_wrow, g_wcol;

  always_comb begin
    if (sel == 0) begin
      g_re = b3.mem_re; g_addr = b3.mem_addr; g_le = b3.LE; g_sh = b3.shift; g_wv = b3.win_valid;
      g_r1 = b3.row_1; g_r2 = b3.row_2; g_r3 = b3.row_3;
      g_wrow = int'(b3.win_row); g_wcol = int'(b3.win_col); g_busy = busy3; g_done = done3;
    end else begin
      g_re = b5.mem_re; g_addr = b5.mem_addr; g_le = b5.LE; g_sh = b5.shift; g_wv = b5.win_valid;
      g_r1 = b5.row_1; g_r2 = b5.row_2; g_r3 = b5.row_3;
      g_wrow = int'(b5.win_row); g_wcol = int'(b5.win_col); g_busy = busy5; g_done = done5;
    end
  end

  typedef struct packed { int row; int col; int cidx; } win_t;

  int              n_checks = 0;
  int              n_fail = 0;
  logic [AW-1:0]   rd_q[$];
  logic [3*DW-1:0] cols[$];
  win_t            win_q[$];
  int              cyc = 0, ndone = 0, viol = 0;
  int              first_wv_cyc = -1, done_cyc = 0, last_hs_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit v);
    start3 = (sel == 0) && v;
    start5 = (sel == 1) && v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (g_re) rd_q.push_back(g_addr);
    if (g_sh) cols.push_back({g_r1, g_r2, g_r3});
    if ((g_le && g_sh) || (g_sh && g_wv)) viol++;
    if (g_wv && first_wv_cyc < 0) first_wv_cyc = cyc;
    if (g_done) begin
      ndone++;
      done_cyc = cyc;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_re"}, 64'(g_re), 64'(0));
    check({tag, "_mem_addr"}, 64'(g_addr), 64'(0));
    check({tag, "_row_1"}, 64'(g_r1), 64'(0));
    check({tag, "_row_2"}, 64'(g_r2), 64'(0));
    check({tag, "_row_3"}, 64'(g_r3), 64'(0));
    check({tag, "_LE"}, 64'(g_le), 64'(0));
    check({tag, "_shift"}, 64'(g_sh), 64'(0));
    check({tag, "_win_valid"}, 64'(g_wv), 64'(0));
    check({tag, "_win_row"}, 64'(g_wrow), 64'(0));
    check({tag, "_win_col"}, 64'(g_wcol), 64'(0));
    check({tag, "_busy"}, 64'(g_busy), 64'(0));
    check({tag, "_done"}, 64'(g_done), 64'(0));
  endtask

  // mode 0: always ready, 1: random ready, 2: ready withheld 10 cycles at first window
  task automatic run_pass(input int W, input int H, input logic [AW-1:0] b, input int mode,
                          input bit start_mid, input bit start_on_done);
    int rd0_cyc, n, stall_cnt, stall_bad, snap_r, snap_c, nrd, idx;
    logic [AW-1:0] ea;
    logic [DW-1:0] pix;
    rd_q.delete(); cols.delete(); win_q.delete();
    ndone = 0; viol = 0; first_wv_cyc = -1; done_cyc = 0; last_hs_cyc = 0;
    stall_cnt = 0; stall_bad = 0; snap_r = 0; snap_c = 0;
    base = b;
    set_start(1'b1);
    tick();
    set_start(1'b0);
    check("busy_after_start", 64'(g_busy), 64'(1));
    rd0_cyc = cyc;
    for (int i = 0; i < 4000 && ndone == 0; i++) begin
      if (mode == 0) ready = 1'b1;
      else if (mode == 1) ready = 1'($urandom_range(0, 1));
      else if (g_wv) begin
        if (stall_cnt == 0) begin snap_r = g_wrow; snap_c = g_wcol; end
        if (stall_cnt > 0 && stall_cnt < 10 && (g_wrow != snap_r || g_wcol != snap_c || g_re || g_sh))
          stall_bad++;
        stall_cnt++;
        ready = (stall_cnt > 10);
      end else begin
        if (stall_cnt > 0 && stall_cnt <= 10) stall_bad++;
        ready = (stall_cnt > 0);
      end
      if (g_wv && ready) begin
        win_q.push_back('{g_wrow, g_wcol, cols.size()});
        last_hs_cyc = cyc;
      end
      set_start(start_mid && (cyc == rd0_cyc + 20));
      tick();
    end
    set_start(1'b0);
    check("done_seen", 64'(ndone), 64'(1));
    if (start_on_done) begin
      set_start(1'b1);
      tick();
      set_start(1'b0);
    end
    nrd = rd_q.size();
    repeat (6) tick();
    check("idle_no_reads", 64'(rd_q.size()), 64'(nrd));
    check("single_done", 64'(ndone), 64'(1));
    check("busy_low_after", 64'(g_busy), 64'(0));
    check("first_valid_latency", 64'(first_wv_cyc - rd0_cyc), 64'(18));
    check("done_after_hs", 64'(done_cyc - last_hs_cyc), 64'(1));
    check("le_shift_valid_exclusive", 64'(viol), 64'(0));
    if (mode == 2) check("stall_stable", 64'(stall_bad), 64'(0));

    check("read_count", 64'(rd_q.size()), 64'(3 * W * (H - 2)));
    n = 0;
    for (int r = 0; r <= H - 3; r++)
      for (int c = 0; c < W; c++)
        for (int k = 0; k < 3; k++) begin
          ea = b + AW'((r + k) * W + c);
          if (n < rd_q.size()) check("read_addr", 64'(rd_q[n]), 64'(ea));
          n++;
        end

    check("window_count", 64'(win_q.size()), 64'((H - 2) * (W - 2)));
    n = 0;
    for (int r = 0; r <= H - 3; r++)
      for (int c = 0; c <= W - 3; c++) begin
        if (n < win_q.size()) begin
          check("win_row", 64'(win_q[n].row), 64'(r));
          check("win_col", 64'(win_q[n].col), 64'(c));
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              idx = win_q[n].cidx - 3 + j;
              pix = (idx >= 0) ? cols[idx][(2 - i) * DW +: DW] : 'x;
              check("win_pixel", 64'(pix), 64'(dfun(b + AW'((r + i) * W + c + j))));
            end
        end
        n++;
      end
  endtask

  initial begin
    int nrd;
    rst = 1'b1;
    repeat (3) tick();
    sel = 0; #1;
    check_reset("reset3");
    sel = 1; #1;
    check_reset("reset5");
    rst = 1'b0;
    tick();

    // 3x3 map, identity memory: one window holding pixels 0..8
    sel = 0; #1;
    seed = '0;
    run_pass(3, 3, 20'h00000, 0, 1'b0, 1'b0);
    // address wrap at the top of the space
    seed = DW'($urandom);
    run_pass(3, 3, 20'hFFFFE, 1, 1'b0, 1'b0);

    sel = 1; #1;
    seed = DW'($urandom);
    run_pass(5, 4, 20'h00100, 0, 1'b0, 1'b0);
    run_pass(5, 4, AW'($urandom), 2, 1'b0, 1'b0);
    run_pass(5, 4, AW'($urandom), 1, 1'b1, 1'b1);

    // reset in RD1 of the second column
    rd_q.delete(); ndone = 0;
    ready = 1'b1;
    base = AW'($urandom);
    set_start(1'b1);
    tick();
    set_start(1'b0);
    for (int i = 0; i < 60 && rd_q.size() < 5; i++) tick();
    check("reset_reached_rd1", 64'(rd_q.size()), 64'(5));
    rst = 1'b1;
    tick();
    check_reset("midpass");
    rst = 1'b0;
    nrd = rd_q.size();
    repeat (8) tick();
    check("reset_no_reads", 64'(rd_q.size()), 64'(nrd));
    check("reset_no_done", 64'(ndone), 64'(0));

    seed = DW'($urandom);
    run_pass(5, 4, AW'($urandom), 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
